// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the IM address and hides its read latency.
// A one-entry skid buffer keeps stall release bubble-free.
module instruction_fetch #(
  parameter int N = 7,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic          clka,
  input  logic          rsta,
  output logic [N-1:0]  addra,
  input  logic [31:0]   douta,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [N-1:0]  branch_target,
  output logic [31:0]   inst,
  output logic [N-1:0]  inst_pc,
  output logic          inst_valid,
  output logic [31:0]   fetch_count
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [N-1:0] PC_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] rsp_pc_q, rsp_pc_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic [N-1:0] hold_pc_q, hold_pc_d;
  logic [31:0]  cnt_q, cnt_d;

  assign addra       = pc_q;
  assign fetch_count = cnt_q;

  // Select the presented instruction from the live IM data or the skid buffer
  always_comb begin
    inst       = 32'h0;
    inst_pc    = '0;
    inst_valid = 1'b0;
    unique case (state_q)
      RUN: begin
        inst       = douta;
        inst_pc    = rsp_pc_q;
        inst_valid = 1'b1;
      end
      HOLD: begin
        inst       = hold_inst_q;
        inst_pc    = hold_pc_q;
        inst_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state: redirect beats stall; issue advances the PC by one word
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    cnt_d       = cnt_q;
    if (branch_taken) begin
      pc_d        = branch_target;
      state_d     = FILL;
      hold_inst_d = 32'h0;
      hold_pc_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          rsp_pc_d = pc_q;
          pc_d     = pc_q + PC_ONE;
          state_d  = RUN;
        end
        RUN: begin
          if (stall) begin
            hold_inst_d = douta;
            hold_pc_d   = rsp_pc_q;
            state_d     = HOLD;
          end else begin
            cnt_d    = cnt_q + 32'd1;
            rsp_pc_d = pc_q;
            pc_d     = pc_q + PC_ONE;
          end
        end
        HOLD: begin
          if (!stall) begin
            cnt_d    = cnt_q + 32'd1;
            rsp_pc_d = pc_q;
            pc_d     = pc_q + PC_ONE;
            state_d  = RUN;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q     <= FILL;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= '0;
      hold_inst_q <= 32'h0;
      hold_pc_q   <= '0;
      cnt_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios then random traffic,
// compared each cycle against a stream-level reference model.
module tb_instruction_fetch;

  localparam int N = 7;

  logic          clk = 1'b0;
  logic          rsta = 1'b1;
  logic [N-1:0]  addra;
  logic [31:0]   douta = 32'h0;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic [N-1:0]  branch_target = '0;
  logic [31:0]   inst;
  logic [N-1:0]  inst_pc;
  logic          inst_valid;
  logic [31:0]   fetch_count;

  int checks = 0;
  int failures = 0;

  // Reference model: what decode should see next, and how many were taken
  bit        m_valid;
  int        m_pc;
  int unsigned m_cnt;

  instruction_fetch #(.N(N), .RESET_PC('0)) dut (
    .clka(clk),
    .rsta(rsta),
    .addra(addra),
    .douta(douta),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Synchronous IM with mem[i] = A000_0000 + i
  always @(posedge clk) douta <= 32'hA000_0000 + 32'(addra);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit b,
                     input int t);
    rsta = r;
    stall = s;
    branch_taken = b;
    branch_target = N'(t);
    @(posedge clk);
    if (r) begin
      m_valid = 0;
      m_pc = 0;
      m_cnt = 0;
    end else if (b) begin
      m_valid = 0;
      m_pc = t % 128;
    end else if (!m_valid) begin
      m_valid = 1;
    end else if (!s) begin
      m_cnt++;
      m_pc = (m_pc + 1) % 128;
    end
    @(negedge clk);
    chk("valid", 32'(inst_valid), 32'(m_valid));
    chk("count", fetch_count, m_cnt);
    if (m_valid) begin
      chk("inst", inst, 32'hA000_0000 + 32'(m_pc));
      chk("pc", 32'(inst_pc), 32'(m_pc));
    end else begin
      chk("inst0", inst, 32'h0);
      chk("pc0", 32'(inst_pc), 32'h0);
      chk("addra", 32'(addra), 32'(m_pc));
    end
  endtask

  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 'h40);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 'h22);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 'h7F);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("cnt9", fetch_count, 32'd9);
    cyc(1, 1, 0, 0);
    chk("rst_addra", 32'(addra), 32'h0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) < 2, $urandom_range(99) < 35,
          $urandom_range(99) < 8, int'($urandom_range(127)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
